fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and fetch sequencer for the 9-bit ISA core. Sits directly upstream of the instruction ROM: drives the 8-bit `InstrAddress` each cycle and steps, branches, stalls or halts under control of the decode/execute stages. Owns the Start/Done handshake with the testbench or host.

## Interface
Parameters:
- `PC_W`, 8: program counter width; must equal the ROM address width.
- `RESET_PC`, 0: PC value loaded on `Reset`.

Ports:
- `CLK`  in  1  core clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  one-cycle pulse; loads `StartAddr` and begins execution.
- `StartAddr`  in  PC_W  program entry address, sampled when `Start`=1.
- `BranchEn`  in  1  redirect fetch this cycle.
- `BranchAbs`  in  1  1 = `Target` is an absolute address; 0 = `Target` is a signed PC-relative offset.
- `Target`  in  PC_W  branch target or two's-complement offset.
- `Stall`  in  1  hold PC this cycle.
- `HaltIn`  in  1  current instruction is HALT (from decode).
- `InstrAddress`  out  PC_W  address to instruction ROM; equals PC register.
- `Running`  out  1  high in RUN state.
- `Done`  out  1  high in HALTED state.
- `InstrCount`  out  16  retired-fetch counter (present only with `FETCH_PERF_EN`).

## Operation
- States: IDLE, RUN, HALTED. PC is a `PC_W`-bit register.
- Reset (any state, any other inputs): state=IDLE, PC=`RESET_PC`, `Running`=0, `Done`=0, `InstrCount`=0. Reset takes priority over `Start`.
- IDLE: PC holds. `Start`=1 -> PC<=`StartAddr`, state<=RUN. All other inputs ignored.
- RUN, priority highest first:
  - `Start`=1: restart; PC<=`StartAddr`, stay RUN.
  - `HaltIn`=1: state<=HALTED, PC holds (points at HALT instruction). Overrides `Stall` and `BranchEn`.
  - `Stall`=1: PC holds; `BranchEn` ignored (decode must re-present it).
  - `BranchEn`=1, `BranchAbs`=1: PC<=`Target`.
  - `BranchEn`=1, `BranchAbs`=0: PC<=PC + sign-extended `Target`, modulo 2^PC_W.
  - otherwise: PC<=PC+1, modulo 2^PC_W (0xFF -> 0x00).
- HALTED: PC holds, `Done`=1. `Start`=1 -> PC<=`StartAddr`, state<=RUN, `Done`<=0. Other inputs ignored.
- `Running`/`Done` are registered state decodes, never both high.
- Control inputs (`BranchEn`, `Stall`, `HaltIn`) are ignored outside RUN.

## Timing
- `InstrAddress` is the PC register directly; ROM read is combinational, so the instruction for PC is valid in the same cycle.
- `Start` in cycle N -> `InstrAddress`=`StartAddr` and `Running`=1 in cycle N+1.
- Branch in cycle N -> target address in cycle N+1; no delay slot, no penalty cycle.
- `HaltIn` in cycle N -> `Done`=1, `Running`=0 in cycle N+1; `InstrAddress` unchanged.
- `Stall` held k cycles -> PC constant for k cycles, advances on first non-stalled cycle.
- Reset asserted in cycle N -> all outputs at reset values in cycle N+1.

## Configuration
- `FETCH_PERF_EN` defined: `InstrCount` port exists; increments by 1 on each RUN cycle where PC advances or branches (not stalled, not halting, not `Start`); cleared to 0 on `Reset` and on any accepted `Start`; saturates at 0xFFFF; holds in IDLE/HALTED.
- `FETCH_PERF_EN` undefined: `InstrCount` port and counter logic absent; all other behaviour identical.

## Test plan
- Reset, then `Start` with `StartAddr`=0x10 -> cycle+1 `InstrAddress`=0x10, `Running`=1; next cycles 0x11, 0x12, 0x13.
- At PC=0x20, `BranchEn`=1,`BranchAbs`=0,`Target`=0xFC -> next PC=0x1C; at 0x1C, `BranchAbs`=1,`Target`=0x80 -> next PC=0x80.
- Wrap: PC=0xFF, no branch -> 0x00; PC=0xFF, relative `Target`=0x02 -> 0x01.
- PC=0x30 with `Stall`=1 and `BranchEn`=1 -> PC stays 0x30; then `HaltIn`=1 with `BranchEn`=1 -> `Done`=1, `Running`=0, PC stays 0x30; `Start`(0x40) -> RUN at 0x40, `Done`=0.
- Reset asserted mid-RUN at PC=0x57 with `Start`=1 same cycle -> IDLE, PC=0x00, `Running`=0, `Done`=0; subsequent cycles PC stays 0x00 until `Start`.
- `FETCH_PERF_EN`: `Start`, 5 advancing cycles, 2 stalled cycles, `HaltIn` -> `InstrCount`=5 held in HALTED; next `Start` clears it to 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: IDLE/RUN/HALTED control of the instruction ROM address.
// Optional retired-fetch counter on InstrCount when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter int unsigned    PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            BranchEn,
  input  logic            BranchAbs,
  input  logic [PC_W-1:0] Target,
  input  logic            Stall,
  input  logic            HaltIn,
  output logic [PC_W-1:0] InstrAddress,
  output logic            Running,
  output logic            Done
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]     InstrCount
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;

  assign InstrAddress = pc;

  // Sequencer: state, PC and the registered Running/Done decodes move together.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (Start) begin
            state   <= RUN;
            pc      <= StartAddr;
            Running <= 1'b1;
            Done    <= 1'b0;
          end
        end
        RUN: begin
          if (Start) begin
            pc <= StartAddr;
          end else if (HaltIn) begin
            state   <= HALTED;
            Running <= 1'b0;
            Done    <= 1'b1;
          end else if (!Stall) begin
            if (BranchEn && BranchAbs) begin
              pc <= Target;
            end else if (BranchEn) begin
              // Offset is already PC_W wide, so a same-width add is the sign-extended sum mod 2^PC_W.
              pc <= PC_W'(pc + Target);
            end else begin
              pc <= PC_W'(pc + PC_W'(1));
            end
          end
        end
        default: begin
          state   <= IDLE;
          pc      <= RESET_PC;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_adv;

  assign fetch_adv = (state == RUN) && !Start && !HaltIn && !Stall;

  // Saturating count of RUN cycles in which the PC stepped or branched.
  always_ff @(posedge CLK) begin
    if (Reset || Start) begin
      InstrCount <= 16'h0000;
    end else if (fetch_adv && (InstrCount != 16'hFFFF)) begin
      InstrCount <= InstrCount + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each step queues its expected outputs, then checks them after the edge.
// Counter checks are included when FETCH_PERF_EN is defined.
module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       Reset, Start, BranchEn, BranchAbs, Stall, HaltIn;
  logic [7:0] StartAddr, Target;
  logic [7:0] InstrAddress;
  logic       Running, Done;
  logic [15:0] cnt_obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [7:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

`ifdef FETCH_PERF_EN
  logic [15:0] InstrCount;
  assign cnt_obs = InstrCount;
`else
  assign cnt_obs = 16'h0000;
`endif

  fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .BranchEn(BranchEn), .BranchAbs(BranchAbs), .Target(Target),
    .Stall(Stall), .HaltIn(HaltIn), .InstrAddress(InstrAddress),
    .Running(Running), .Done(Done)
`ifdef FETCH_PERF_EN
    , .InstrCount(InstrCount)
`endif
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, queue the expected result, then compare after the rising edge.
  task automatic step(input string tag, input logic rst, input logic st, input logic [7:0] sa,
                      input logic br, input logic ab, input logic [7:0] tg, input logic stl,
                      input logic hlt, input logic [7:0] e_pc, input logic e_run,
                      input logic e_done, input logic [15:0] e_cnt);
    exp_t e, g;
    Reset = rst; Start = st; StartAddr = sa; BranchEn = br; BranchAbs = ab;
    Target = tg; Stall = stl; HaltIn = hlt;
    e.tag = tag; e.pc = e_pc; e.run = e_run; e.done = e_done; e.cnt = e_cnt;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    g = sb.pop_front();
    checks++;
    assert (InstrAddress === g.pc) else begin
      errors++;
      $error("FAIL %s pc observed %h expected %h", g.tag, InstrAddress, g.pc);
    end
    checks++;
    assert (Running === g.run) else begin
      errors++;
      $error("FAIL %s running observed %b expected %b", g.tag, Running, g.run);
    end
    checks++;
    assert (Done === g.done) else begin
      errors++;
      $error("FAIL %s done observed %b expected %b", g.tag, Done, g.done);
    end
`ifdef FETCH_PERF_EN
    checks++;
    assert (cnt_obs === g.cnt) else begin
      errors++;
      $error("FAIL %s count observed %0d expected %0d", g.tag, cnt_obs, g.cnt);
    end
`endif
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; StartAddr = 8'h00; BranchEn = 1'b0; BranchAbs = 1'b0;
    Target = 8'h00; Stall = 1'b0; HaltIn = 1'b0;
    @(posedge CLK); #1;
    //    tag           rst st  sa     br ab tg     stl hlt  pc     run done cnt
    step("reset",       1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 16'd0);
    step("idle_hold",   0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 16'd0);
    step("idle_ignore", 0, 0, 8'h00, 1, 1, 8'h44, 1, 1, 8'h00, 0, 0, 16'd0);
    step("start_10",    0, 1, 8'h10, 0, 0, 8'h00, 0, 0, 8'h10, 1, 0, 16'd0);
    step("seq_11",      0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h11, 1, 0, 16'd1);
    step("seq_12",      0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h12, 1, 0, 16'd2);
    step("seq_13",      0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h13, 1, 0, 16'd3);
    step("abs_20",      0, 0, 8'h00, 1, 1, 8'h20, 0, 0, 8'h20, 1, 0, 16'd4);
    step("rel_m4",      0, 0, 8'h00, 1, 0, 8'hFC, 0, 0, 8'h1C, 1, 0, 16'd5);
    step("abs_80",      0, 0, 8'h00, 1, 1, 8'h80, 0, 0, 8'h80, 1, 0, 16'd6);
    step("abs_ff",      0, 0, 8'h00, 1, 1, 8'hFF, 0, 0, 8'hFF, 1, 0, 16'd7);
    step("wrap_inc",    0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 16'd8);
    step("abs_ff2",     0, 0, 8'h00, 1, 1, 8'hFF, 0, 0, 8'hFF, 1, 0, 16'd9);
    step("wrap_rel",    0, 0, 8'h00, 1, 0, 8'h02, 0, 0, 8'h01, 1, 0, 16'd10);
    step("abs_30",      0, 0, 8'h00, 1, 1, 8'h30, 0, 0, 8'h30, 1, 0, 16'd11);
    step("stall_br",    0, 0, 8'h00, 1, 1, 8'h99, 1, 0, 8'h30, 1, 0, 16'd11);
    step("halt_br",     0, 0, 8'h00, 1, 1, 8'h99, 0, 1, 8'h30, 0, 1, 16'd11);
    step("halted_ign",  0, 0, 8'h00, 1, 1, 8'h99, 1, 1, 8'h30, 0, 1, 16'd11);
    step("start_40",    0, 1, 8'h40, 0, 0, 8'h00, 0, 0, 8'h40, 1, 0, 16'd0);
    step("abs_57",      0, 0, 8'h00, 1, 1, 8'h57, 0, 0, 8'h57, 1, 0, 16'd1);
    step("rst_start",   1, 1, 8'h99, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 16'd0);
    step("post_rst1",   0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 16'd0);
    step("post_rst2",   0, 0, 8'h00, 1, 0, 8'h05, 0, 0, 8'h00, 0, 0, 16'd0);
    step("start_60",    0, 1, 8'h60, 0, 0, 8'h00, 0, 0, 8'h60, 1, 0, 16'd0);
    step("adv_61",      0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h61, 1, 0, 16'd1);
    step("adv_62",      0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h62, 1, 0, 16'd2);
    step("adv_63",      0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h63, 1, 0, 16'd3);
    step("adv_64",      0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h64, 1, 0, 16'd4);
    step("adv_65",      0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h65, 1, 0, 16'd5);
    step("stall_1",     0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h65, 1, 0, 16'd5);
    step("stall_2",     0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h65, 1, 0, 16'd5);
    step("halt_65",     0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h65, 0, 1, 16'd5);
    step("halted_hold", 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h65, 0, 1, 16'd5);
    step("start_70",    0, 1, 8'h70, 0, 0, 8'h00, 0, 0, 8'h70, 1, 0, 16'd0);
    step("adv_71",      0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h71, 1, 0, 16'd1);
    step("restart_05",  0, 1, 8'h05, 1, 1, 8'h99, 0, 1, 8'h05, 1, 0, 16'd0);
    step("adv_06",      0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h06, 1, 0, 16'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
